// File: rtl/coin_pkg.sv
// ---------------------------------------------------------------------------
// coin_pkg
// Shared definitions for the coin event scheduler:
//   - coin codes carried on coin_code (COIN_HALF / COIN_ONE)
//   - output FSM state encoding
//   - default timing constants for a 50 MHz system clock
// ---------------------------------------------------------------------------
package coin_pkg;

  localparam logic COIN_HALF = 1'b0;
  localparam logic COIN_ONE  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // 20 ms debounce, 1 s pacing at 50 MHz
  localparam int DB_CYCLES_50MHZ    = 1000000;
  localparam int PACE_CYCLES_50MHZ  = 50000000;
  localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/coin_debounce.sv
// ---------------------------------------------------------------------------
// coin_debounce
// One button channel: 2-flop synchronizer, debounce counter and a registered
// one-cycle pulse on every accepted 1->0 transition of the debounced level.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-low reset (button reads as released)
//   btn_n  in   raw active-low button, asynchronous to clk
//   fall   out  one-cycle pulse when the debounced level goes 1 -> 0
//
// Latency from a clean raw falling edge to fall: 2 + DB_CYCLES cycles.
// ---------------------------------------------------------------------------
module coin_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic fall
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          fall_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
      fall_reg  <= 1'b0;
      // Count consecutive samples that disagree with the accepted level; any
      // sample agreeing with it (a bounce back) restarts the count.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DB_CYCLES - 1)) begin
        level_reg <= sync2_reg;
        fall_reg  <= ~sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign fall = fall_reg;

endmodule

// File: rtl/coin_event_scheduler.sv
// ---------------------------------------------------------------------------
// coin_event_scheduler
// Debounces the half / one coin buttons, turns each press into a pending
// flag, arbitrates the flags into a small FIFO and offers the buffered coin
// events to the vending core over valid/ready, with a minimum pacing gap
// between handshakes.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-low reset
//   half_btn_n  in   raw half-dollar button (active-low, async)
//   one_btn_n   in   raw one-dollar button (active-low, async)
//   coin_valid  out  coin event offered
//   coin_code   out  0 = half, 1 = one (0 while coin_valid = 0)
//   coin_ready  in   vending core accepts the offered event
//   fifo_level  out  buffered events, including the one being offered
//   drop_pulse  out  one-cycle pulse when a press is discarded
//   busy        out  events buffered or pacing gap still running
//
// Build option: COIN_ARB_RR_EN selects round-robin arbitration between
// simultaneously pending channels; otherwise half always wins.
// ---------------------------------------------------------------------------
module coin_event_scheduler
  import coin_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_50MHZ,
  parameter int PACE_CYCLES = PACE_CYCLES_50MHZ,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        half_btn_n,
  input  logic                        one_btn_n,
  output logic                        coin_valid,
  output logic                        coin_code,
  input  logic                        coin_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        drop_pulse,
  output logic                        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;

  logic half_fall;
  logic one_fall;

  coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_half_db (
    .clk   (clk),
    .reset (reset),
    .btn_n (half_btn_n),
    .fall  (half_fall)
  );

  coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_one_db (
    .clk   (clk),
    .reset (reset),
    .btn_n (one_btn_n),
    .fall  (one_fall)
  );

  // ---------------- pending flags and arbitration -------------------------
  logic pend_half_reg;
  logic pend_one_reg;
  logic drop_pulse_reg;
  logic grant_half;
  logic grant_one;
  logic push;
  logic push_code;
  logic pop;
  logic space;

  logic          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;

  // A full FIFO still has room when the head is popped in the same cycle.
  assign space = (level_reg != LW'(FIFO_DEPTH)) || pop;

`ifdef COIN_ARB_RR_EN
  logic last_grant_reg;

  always_comb begin
    grant_half = 1'b0;
    grant_one  = 1'b0;
    if (space) begin
      if (pend_half_reg && pend_one_reg) begin
        // Contention: the channel not granted last time wins.
        grant_half = (last_grant_reg == COIN_ONE);
        grant_one  = (last_grant_reg == COIN_HALF);
      end else begin
        grant_half = pend_half_reg;
        grant_one  = pend_one_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_reg <= COIN_ONE;
    end else if (push && pend_half_reg && pend_one_reg) begin
      last_grant_reg <= push_code;
    end
  end
`else
  always_comb begin
    grant_half = 1'b0;
    grant_one  = 1'b0;
    if (space) begin
      grant_half = pend_half_reg;
      grant_one  = pend_one_reg && !pend_half_reg;
    end
  end
`endif

  assign push      = grant_half || grant_one;
  assign push_code = grant_one ? COIN_ONE : COIN_HALF;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_half_reg  <= 1'b0;
      pend_one_reg   <= 1'b0;
      drop_pulse_reg <= 1'b0;
    end else begin
      // A new press only sets an idle flag; a press onto a set flag is lost.
      pend_half_reg  <= (pend_half_reg && !grant_half) || (half_fall && !pend_half_reg);
      pend_one_reg   <= (pend_one_reg && !grant_one) || (one_fall && !pend_one_reg);
      drop_pulse_reg <= (half_fall && pend_half_reg) || (one_fall && pend_one_reg);
    end
  end

  // ---------------- coin event FIFO ---------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // ---------------- output FSM and pacing ---------------------------------
  state_t        state_reg;
  state_t        state_next;
  logic [TW-1:0] pace_reg;
  logic [TW-1:0] pace_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      pace_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pace_reg  <= pace_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pace_next  = pace_reg;
    pop        = 1'b0;
    coin_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (level_reg != '0 && pace_reg == '0) state_next = ST_OFFER;
      end
      ST_OFFER: begin
        coin_valid = 1'b1;
        if (coin_ready) begin
          pop        = 1'b1;
          pace_next  = TW'(PACE_CYCLES - 1);
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        // Leave on the edge where the counter lands on zero.
        if (pace_reg <= TW'(1)) begin
          pace_next  = '0;
          state_next = ST_IDLE;
        end else begin
          pace_next = pace_reg - TW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign coin_code  = coin_valid ? mem[rd_ptr_reg] : COIN_HALF;
  assign fifo_level = level_reg;
  assign drop_pulse = drop_pulse_reg;
  assign busy       = (level_reg != '0) || (pace_reg != '0);

endmodule
